// File: rtl/mlp_inference_sequencer_if.sv
// Stream, network and result signals of the MLP inference sequencer.
// Perf ports exist only when INFER_PERF_CNT_EN is defined.
interface mlp_inference_sequencer_if #(
  parameter int WIDTH    = 16,
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 5,
  parameter int CLS_W    = 3
);
  logic                             in_valid;
  logic                             in_ready;
  logic [IN_SIZE-1:0][WIDTH-1:0]    in_data;
  logic [IN_SIZE-1:0][WIDTH-1:0]    net_data;
  logic                             net_start;
  logic                             net_done;
  logic [OUT_SIZE-1:0][WIDTH-1:0]   net_result;
  logic                             out_valid;
  logic                             out_ready;
  logic [OUT_SIZE-1:0][WIDTH-1:0]   out_data;
  logic [CLS_W-1:0]                 out_class;
  logic                             out_timeout;
  logic                             busy;
`ifdef INFER_PERF_CNT_EN
  logic [31:0]                      perf_frames;
  logic [15:0]                      perf_timeouts;
  logic [15:0]                      perf_last_lat;
`endif

  modport slave (
    input  in_valid, in_data, net_done,
    input  net_result, out_ready,
    output in_ready, net_data, net_start,
    output out_valid, out_data, out_class,
    output out_timeout, busy
`ifdef INFER_PERF_CNT_EN
    , output perf_frames, perf_timeouts
    , output perf_last_lat
`endif
  );

  modport master (
    output in_valid, in_data, net_done,
    output net_result, out_ready,
    input  in_ready, net_data, net_start,
    input  out_valid, out_data, out_class,
    input  out_timeout, busy
`ifdef INFER_PERF_CNT_EN
    , input perf_frames, perf_timeouts
    , input perf_last_lat
`endif
  );
endinterface

// File: rtl/mlp_inference_sequencer.sv
// One-frame-in-flight sequencer: accept, launch, wait/timeout, argmax.
// Optional perf counters via INFER_PERF_CNT_EN.
module mlp_inference_sequencer #(
  parameter int WIDTH    = 16,
  parameter int NFRAC    = 10,
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 5,
  parameter int TIMEOUT  = 1024,
  parameter int CLS_W    = 3
) (
  input logic                 clk,
  input logic                 reset,
  mlp_inference_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  if (TIMEOUT < 2 || (1 << CLS_W) < OUT_SIZE ||
      NFRAC >= WIDTH || IN_SIZE < 1) begin : g_bad_cfg
    $error("mlp_inference_sequencer: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, LAUNCH, WAIT, PRESENT
  } state_t;

  state_t           state, state_nx;
  logic             done_q;
  logic             done_evt;
  logic             tmo_hit;
  logic             accept;
  logic             cap_done;
  logic             cap_to;
  logic [CNT_W-1:0] cnt;
  logic [CLS_W-1:0] best_idx;
  logic [WIDTH-1:0] best;

  assign done_evt = bus.net_done & ~done_q;
  assign tmo_hit  = (cnt == CNT_W'(TIMEOUT - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.net_start = (state == LAUNCH);
  assign bus.out_valid = (state == PRESENT);
  assign bus.busy      = (state != IDLE);

  // argmax, signed, ties keep the lowest index
  always_comb begin
    best_idx = '0;
    best     = bus.net_result[0];
    for (int i = 1; i < OUT_SIZE; i++) begin
      if ($signed(bus.net_result[i]) > $signed(best)) begin
        best     = bus.net_result[i];
        best_idx = CLS_W'(i);
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and capture strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cap_done = 1'b0;
    cap_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        if (done_evt) begin
          cap_done = 1'b1;
          state_nx = PRESENT;
        end else if (tmo_hit) begin
          cap_to   = 1'b1;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: features, wait counter, result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q          <= 1'b0;
      cnt             <= '0;
      bus.net_data    <= '0;
      bus.out_data    <= '0;
      bus.out_class   <= '0;
      bus.out_timeout <= 1'b0;
    end else begin
      done_q <= bus.net_done;
      if (accept) bus.net_data <= bus.in_data;
      if (state == LAUNCH)
        cnt <= '0;
      else if (state == WAIT && !done_evt && !tmo_hit)
        cnt <= cnt + CNT_W'(1);
      if (cap_done) begin
        bus.out_data    <= bus.net_result;
        bus.out_class   <= best_idx;
        bus.out_timeout <= 1'b0;
      end
      if (cap_to) begin
        bus.out_data    <= '0;
        bus.out_class   <= '0;
        bus.out_timeout <= 1'b1;
      end
    end
  end

`ifdef INFER_PERF_CNT_EN
  logic [31:0] lat_full;
  logic [15:0] lat_sat;

  assign lat_full = 32'(cnt) + 32'd1;
  assign lat_sat  = (lat_full > 32'h0000_FFFF) ?
                    16'hFFFF : lat_full[15:0];

  // frame, timeout and latency counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.perf_frames   <= '0;
      bus.perf_timeouts <= '0;
      bus.perf_last_lat <= '0;
    end else begin
      if (cap_done) begin
        bus.perf_frames   <= bus.perf_frames + 32'd1;
        bus.perf_last_lat <= lat_sat;
      end
      if (cap_to)
        bus.perf_timeouts <= bus.perf_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mlp_inference_sequencer.sv
// Directed bench for mlp_inference_sequencer (TIMEOUT=16).
// Perf checks run when INFER_PERF_CNT_EN is defined.
module tb_mlp_inference_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  always #5 clk = ~clk;

  mlp_inference_sequencer_if #(
    .WIDTH(16), .IN_SIZE(16), .OUT_SIZE(5), .CLS_W(3)
  ) bus ();

  mlp_inference_sequencer #(
    .WIDTH(16), .NFRAC(10), .IN_SIZE(16),
    .OUT_SIZE(5), .TIMEOUT(16), .CLS_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

`ifdef INFER_PERF_CNT_EN
  task automatic frame(input int lat);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (lat > 0) begin
      repeat (lat) tick();
      bus.net_done = 1'b1;
      tick();
      bus.net_done = 1'b0;
    end
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("perf_frame_done", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.net_done   = 1'b0;
    bus.net_result = '0;
    bus.out_ready  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_net_start", bus.net_start, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_timeout", bus.out_timeout, 1'b0);
    chk("rst_class", bus.out_class, 3'd0);
    chk("rst_net_data", bus.net_data, '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b1;
    tick();

    // 1: normal frame, latency 8, tie 1 vs 4
    bus.in_data  = {16{16'h0400}};
    bus.in_valid = 1'b1;
    chk("t1_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_start_hi", bus.net_start, 1'b1);
    chk("t1_in_ready_lo", bus.in_ready, 1'b0);
    chk("t1_net_data", bus.net_data, {16{16'h0400}});
    tick();
    chk("t1_start_lo", bus.net_start, 1'b0);
    repeat (7) tick();
    bus.net_done   = 1'b1;
    bus.net_result = {16'h0C00, 16'hFF00, 16'h0200,
                      16'h0C00, 16'h0100};
    chk("t1_no_valid_yet", bus.out_valid, 1'b0);
    tick();
    chk("t1_out_valid", bus.out_valid, 1'b1);
    chk("t1_class", bus.out_class, 3'd1);
    chk("t1_timeout", bus.out_timeout, 1'b0);
    chk("t1_out_data", bus.out_data,
        {16'h0C00, 16'hFF00, 16'h0200,
         16'h0C00, 16'h0100});

    // 2: hold in PRESENT with a new frame pending
    bus.in_data  = {16{16'h0123}};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_hold_valid", bus.out_valid, 1'b1);
      chk("t2_in_ready_lo", bus.in_ready, 1'b0);
    end
    chk("t2_class", bus.out_class, 3'd1);
    chk("t2_out_data", bus.out_data,
        {16'h0C00, 16'hFF00, 16'h0200,
         16'h0C00, 16'h0100});
    chk("t2_net_data", bus.net_data, {16{16'h0400}});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t2_in_ready_back", bus.in_ready, 1'b1);
    chk("t2_valid_drop", bus.out_valid, 1'b0);

    // 3: stale net_done stays high across launch
    tick();
    bus.in_valid = 1'b0;
    chk("t3_start", bus.net_start, 1'b1);
    chk("t3_net_data", bus.net_data, {16{16'h0123}});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stale_ignored", bus.out_valid, 1'b0);
    end
    bus.net_done   = 1'b0;
    bus.net_result = {5{16'h7FFF}};
    tick();
    bus.net_done   = 1'b1;
    bus.net_result = {16'h0001, 16'h0000, 16'h0001,
                      16'hF800, 16'hF000};
    tick();
    chk("t3_valid", bus.out_valid, 1'b1);
    chk("t3_class", bus.out_class, 3'd2);
    chk("t3_out_data", bus.out_data,
        {16'h0001, 16'h0000, 16'h0001,
         16'hF800, 16'hF000});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.net_done  = 1'b0;
    chk("t3_idle", bus.busy, 1'b0);

    // 4: timeout, 16 WAIT cycles
    bus.in_data  = {16{16'h0555}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_start", bus.net_start, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      if (!bus.out_valid) n++;
    end
    chk("t4_wait_cycles", 32'(n), 32'd16);
    chk("t4_timeout", bus.out_timeout, 1'b1);
    chk("t4_out_data", bus.out_data, '0);
    chk("t4_class", bus.out_class, 3'd0);
    chk("t4_net_data", bus.net_data, {16{16'h0555}});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // 5: async reset mid-WAIT, then a clean frame
    bus.in_data  = {16{16'h0777}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("t5_busy_pre", bus.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_in_ready", bus.in_ready, 1'b1);
    chk("t5_net_data", bus.net_data, '0);
    chk("t5_timeout", bus.out_timeout, 1'b0);
    chk("t5_out_valid", bus.out_valid, 1'b0);
    tick();
    reset = 1'b1;
    bus.in_data  = {16{16'h0111}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.net_done   = 1'b1;
    bus.net_result = {16'h0005, 16'h0004, 16'h0003,
                      16'h0002, 16'h0001};
    tick();
    bus.net_done = 1'b0;
    chk("t5_valid", bus.out_valid, 1'b1);
    chk("t5_class", bus.out_class, 3'd4);
    chk("t5_out_data", bus.out_data,
        {16'h0005, 16'h0004, 16'h0003,
         16'h0002, 16'h0001});
    chk("t5_net_data2", bus.net_data, {16{16'h0111}});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

`ifdef INFER_PERF_CNT_EN
    // 6: perf counters after fresh reset
    #2;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    frame(8);
    frame(8);
    frame(8);
    frame(0);
    chk("t6_frames", bus.perf_frames, 32'd3);
    chk("t6_timeouts", bus.perf_timeouts, 16'd1);
    chk("t6_last_lat", bus.perf_last_lat, 16'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mlp_inference_sequencer.md
Name: mlp_inference_sequencer

Overview:
Frame-level controller that sequences one inference of the fixed-point MLP jet-tagging network (dense/ReLU chain plus softmax).
- Accepts an input feature vector over a valid/ready stream and holds it stable on the network inputs.
- Issues a single start pulse, then waits for the network's done level to rise, with a timeout.
- Captures the scores, computes argmax, and presents the result over a second valid/ready stream.
- Sits between the feature source (DMA/testbench) and the network top; only one frame is in flight at a time.

Parameters:
WIDTH, 16, bit width of every fixed-point element
NFRAC, 10, fractional bits (used for debug real conversion only; no arithmetic effect)
IN_SIZE, 16, number of input features
OUT_SIZE, 5, number of class scores
TIMEOUT, 1024, max cycles in WAIT before abort; must be >= 2
CLS_W, 3, width of class index; must satisfy 2**CLS_W >= OUT_SIZE

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
in_valid  in  1  source presents a frame
in_ready  out  1  sequencer accepts a frame
in_data  in  WIDTH x IN_SIZE (signed)  input features
net_data  out  WIDTH x IN_SIZE (signed)  registered features driven to network input_data
net_start  out  1  one-cycle start pulse to network input_ready
net_done  in  1  network output_ready (level)
net_result  in  WIDTH x OUT_SIZE (signed)  network output_data
out_valid  out  1  result available
out_ready  in  1  sink accepts result
out_data  out  WIDTH x OUT_SIZE (signed)  captured scores
out_class  out  CLS_W  argmax index of out_data
out_timeout  out  1  result is a timeout abort, not a real inference
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=1; net_start=0; out_valid=0; out_timeout=0; out_class=0; net_data, out_data all 0; timeout counter 0; done_q=0.
- done_q is a register copy of net_done. done_evt = net_done & ~done_q (rising edge). A stale high net_done from the previous frame never completes a new frame.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into net_data and go to LAUNCH.
- LAUNCH: in_ready=0; net_start=1 for exactly this cycle; clear counter; go to WAIT.
- WAIT, done_evt takes priority over timeout:
  - done_evt=1: latch net_result into out_data; latch argmax into out_class; out_timeout=0; go to PRESENT.
  - done_evt=0 and counter==TIMEOUT-1: out_data=all 0, out_class=0, out_timeout=1; go to PRESENT.
  - otherwise increment counter.
- PRESENT: out_valid=1; out_data/out_class/out_timeout held stable. On out_valid&out_ready go to IDLE; out_valid falls the next cycle.
- net_data stays stable from capture until the next accepted frame; it does not change in LAUNCH, WAIT or PRESENT.
- Argmax: signed compare across all OUT_SIZE elements; strictly-greater replaces; ties go to the lowest index.
- Latency: frame accepted at edge T; net_start high in cycle T+1; done_evt sampled at edge D gives out_valid high from D+1. No back-to-back acceptance: in_ready returns in the cycle after the out handshake.
- net_done and net_result are ignored in IDLE, LAUNCH and PRESENT.
- Reset asserted mid-frame returns everything to reset values immediately; any pending result is discarded.

Optional Feature:
INFER_PERF_CNT_EN:
- Defined:
  - Adds outputs perf_frames (32 bit, count of completed non-timeout frames), perf_timeouts (16 bit) and perf_last_lat (16 bit, cycles from net_start to done_evt inclusive, saturating).
  - Counters update on the WAIT→PRESENT transition and clear on reset only.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Reset, then in_data all 0x0400 with in_valid=1 → in_ready=1 in cycle 0; net_start high exactly one cycle; net_data=0x0400 held. Network model raises net_done 8 cycles later with scores {0x0100,0x0C00,0x0200,0xFF00,0x0C00} → out_valid next cycle; out_class=1 (tie with index 4 resolves low); out_timeout=0.
2. Hold out_ready=0 for 20 cycles in PRESENT → out_valid, out_data and out_class stable; in_ready=0 while in_valid=1. Assert out_ready → in_ready=1 the following cycle.
3. net_done stuck high from the previous frame, new frame launched → no completion until net_done drops and re-rises; result equals the scores at the re-rise.
4. net_done never rises, TIMEOUT=16 → out_valid exactly 16 cycles after net_start, out_timeout=1, out_data=0, out_class=0.
5. Assert reset=0 mid-WAIT (asynchronously, between edges) → outputs go to reset values without a clock edge; the next frame completes normally.
6. With INFER_PERF_CNT_EN: run 3 good frames at latency 8 and 1 timeout → perf_frames=3, perf_timeouts=1, perf_last_lat=8.
